// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types, widths and digit limits for the BCD stopwatch
package stopwatch_pkg;

    localparam int BCD_W            = 4;
    localparam int NUM_DIGITS       = 6;
    localparam int COUNT_W          = BCD_W * NUM_DIGITS;
    localparam int MIN_TENS_MAX_DEF = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        PAUSE     = 3'd2,
        RUN_LAP   = 3'd3,
        PAUSE_LAP = 3'd4
    } sw_state_t;

    // Digit index 0 is c1 (least significant), index 5 is m10.
    // Limits from m10 down to c1 are {min_tens_max, 9, 5, 9, 9, 9}.
    function automatic int digit_max(input int idx, input int min_tens_max);
        case (idx)
            3:       return 5;
            5:       return min_tens_max;
            default: return 9;
        endcase
    endfunction

    // Packed terminal value, e.g. 24'h595999 for the default 59:59.99.
    function automatic logic [COUNT_W-1:0] count_max(input int min_tens_max);
        logic [COUNT_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            v[i*BCD_W +: BCD_W] = BCD_W'(digit_max(i, min_tens_max));
        end
        return v;
    endfunction

    function automatic logic is_running(input sw_state_t s);
        return (s == RUN) || (s == RUN_LAP);
    endfunction

    function automatic logic is_lap(input sw_state_t s);
        return (s == RUN_LAP) || (s == PAUSE_LAP);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one BCD digit with a configurable top value and carry out
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    localparam logic [BCD_W-1:0] L_MAX = BCD_W'(MAX);

    logic [BCD_W-1:0] r_digit;

    // Advance on inc; any value at or beyond the limit folds back to zero.
    always_ff @(posedge clk_in) begin
        if (rst || clr) begin
            r_digit <= '0;
        end else if (inc) begin
            if (r_digit >= L_MAX) begin
                r_digit <= '0;
            end else begin
                r_digit <= r_digit + BCD_W'(1);
            end
        end
    end

    // Carry only on a genuine wrap from the limit, so a corrupt digit never ripples upward.
    assign carry_out = inc && (r_digit == L_MAX);
    assign digit     = r_digit;

endmodule

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - MM:SS.cc BCD stopwatch with run/pause, clear and lap freeze
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int WRAP         = 1,
    parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               tick,
    input  logic               start_stop,
    input  logic               clear,
    input  logic               lap,
    output logic [COUNT_W-1:0] disp_digits,
    output logic               running,
    output logic               lap_active,
    output logic               rollover
);

    localparam logic [COUNT_W-1:0] L_COUNT_MAX = count_max(MIN_TENS_MAX);
    // c1 of the terminal value is 9, so subtracting one only touches c1.
    localparam logic [COUNT_W-1:0] L_COUNT_PRE = L_COUNT_MAX - COUNT_W'(1);
    localparam logic               L_WRAP      = (WRAP != 0);

    sw_state_t          r_state;
    sw_state_t          w_state_nxt;
    logic               r_running;
    logic               r_lap_active;
    logic               r_rollover;
    logic [COUNT_W-1:0] r_latch;
    logic [COUNT_W-1:0] r_disp;

    logic [COUNT_W-1:0]    w_count;
    logic [NUM_DIGITS-1:0] w_carry;
    logic [NUM_DIGITS-1:0] w_dinc;
    logic                  w_at_max;
    logic                  w_at_pre;
    logic                  w_hold_term;
    logic                  w_inc;
    logic                  w_term;
    logic                  w_roll;
    logic                  w_latch_cap;

    assign w_at_max    = (w_count == L_COUNT_MAX);
    assign w_at_pre    = (w_count == L_COUNT_PRE);
    // Saturating build parked at the top value: the count is frozen until clear.
    assign w_hold_term = !L_WRAP && w_at_max;

    // Counting follows the registered state, so the start pulse's own tick is not counted
    // while the stop pulse's tick still is.
    assign w_inc  = tick && is_running(r_state) && !clear && !w_hold_term;
    assign w_term = !L_WRAP && w_inc && w_at_pre;
    assign w_roll = L_WRAP ? w_carry[NUM_DIGITS-1] : w_term;

    // Only a lap that is actually acted on from RUN captures the pre-increment count.
    assign w_latch_cap = !clear && !start_stop && lap && (r_state == RUN);

    assign w_dinc = {w_carry[NUM_DIGITS-2:0], w_inc};

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit_counter #(
                .MAX(digit_max(g, MIN_TENS_MAX))
            ) u_digit (
                .clk_in    (clk_in),
                .rst       (rst),
                .clr       (clear),
                .inc       (w_dinc[g]),
                .digit     (w_count[g*BCD_W +: BCD_W]),
                .carry_out (w_carry[g])
            );
        end
    endgenerate

    // Next state: clear beats start_stop beats lap; saturation then forces a pause.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else if (start_stop) begin
            case (r_state)
                IDLE:      w_state_nxt = RUN;
                RUN:       w_state_nxt = PAUSE;
                RUN_LAP:   w_state_nxt = PAUSE_LAP;
                PAUSE:     w_state_nxt = w_hold_term ? PAUSE : RUN;
                PAUSE_LAP: w_state_nxt = w_hold_term ? PAUSE_LAP : RUN_LAP;
                default:   w_state_nxt = IDLE;
            endcase
        end else if (lap) begin
            case (r_state)
                RUN:       w_state_nxt = RUN_LAP;
                RUN_LAP:   w_state_nxt = RUN;
                PAUSE_LAP: w_state_nxt = PAUSE;
                IDLE:      w_state_nxt = IDLE;
                PAUSE:     w_state_nxt = PAUSE;
                default:   w_state_nxt = IDLE;
            endcase
        end
        if (w_term) begin
            if (w_state_nxt == RUN) begin
                w_state_nxt = PAUSE;
            end else if (w_state_nxt == RUN_LAP) begin
                w_state_nxt = PAUSE_LAP;
            end
        end
    end

    // Control FSM with status flags registered alongside the state they describe.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state      <= IDLE;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_rollover   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_running    <= is_running(w_state_nxt);
            r_lap_active <= is_lap(w_state_nxt);
            r_rollover   <= w_roll;
        end
    end

    // Lap latch: snapshot of the live count taken when the display freezes.
    always_ff @(posedge clk_in) begin
        if (rst || clear) begin
            r_latch <= '0;
        end else if (w_latch_cap) begin
            r_latch <= w_count;
        end
    end

    // Display register: one cycle behind the count, showing the latch while frozen.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_disp <= '0;
        end else begin
            r_disp <= is_lap(r_state) ? r_latch : w_count;
        end
    end

    assign disp_digits = r_disp;
    assign running     = r_running;
    assign lap_active  = r_lap_active;
    assign rollover    = r_rollover;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - randomized and directed checks of stopwatch_bcd against a centisecond model
module tb_stopwatch_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst        = 1'b1;
    logic tick       = 1'b0;
    logic start_stop = 1'b0;
    logic clear      = 1'b0;
    logic lap        = 1'b0;

    logic [23:0] o_disp [3];
    logic        o_run  [3];
    logic        o_lap  [3];
    logic        o_roll [3];

    int total = 0;
    int bad   = 0;

    // Instance 0: default build. Instances 1/2 top out at 09:59.99 so the terminal
    // count is reachable in a short run; 1 wraps, 2 saturates.
    stopwatch_bcd u_dut_a (
        .clk_in(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
        .disp_digits(o_disp[0]), .running(o_run[0]), .lap_active(o_lap[0]), .rollover(o_roll[0])
    );
    stopwatch_bcd #(.WRAP(1), .MIN_TENS_MAX(0)) u_dut_w (
        .clk_in(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
        .disp_digits(o_disp[1]), .running(o_run[1]), .lap_active(o_lap[1]), .rollover(o_roll[1])
    );
    stopwatch_bcd #(.WRAP(0), .MIN_TENS_MAX(0)) u_dut_s (
        .clk_in(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
        .disp_digits(o_disp[2]), .running(o_run[2]), .lap_active(o_lap[2]), .rollover(o_roll[2])
    );

    // Model: elapsed time as plain centiseconds plus three booleans.
    int m_cnt     [3];
    int m_latch   [3];
    int m_dval    [3];
    bit m_started [3];
    bit m_go      [3];
    bit m_frozen  [3];
    bit m_roll    [3];

    function automatic bit wraps(input int k);
        return k != 2;
    endfunction

    function automatic int top_cs(input int k);
        return (k == 0) ? 359999 : 59999;
    endfunction

    function automatic logic [23:0] to_bcd(input int c);
        int m, s, cs;
        cs = c % 100;
        s  = (c / 100) % 60;
        m  = c / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic model_step(input int k, input bit rs, input bit ss, input bit cl,
                              input bit lp, input bit tk);
        bit adv;
        m_roll[k] = 1'b0;
        if (rs) begin
            m_cnt[k] = 0; m_latch[k] = 0; m_dval[k] = 0;
            m_started[k] = 0; m_go[k] = 0; m_frozen[k] = 0;
            return;
        end
        m_dval[k] = m_frozen[k] ? m_latch[k] : m_cnt[k];
        if (cl) begin
            m_cnt[k] = 0; m_latch[k] = 0;
            m_started[k] = 0; m_go[k] = 0; m_frozen[k] = 0;
            return;
        end
        adv = tk && m_go[k];
        if (ss) begin
            if (!m_started[k]) begin
                m_started[k] = 1; m_go[k] = 1;
            end else if (m_go[k]) begin
                m_go[k] = 0;
            end else if (wraps(k) || m_cnt[k] != top_cs(k)) begin
                m_go[k] = 1;
            end
        end else if (lp) begin
            if (m_go[k]) begin
                m_frozen[k] = !m_frozen[k];
                if (m_frozen[k]) m_latch[k] = m_cnt[k];
            end else if (m_frozen[k]) begin
                m_frozen[k] = 0;
            end
        end
        if (adv) begin
            if (m_cnt[k] == top_cs(k)) begin
                m_cnt[k]  = 0;
                m_roll[k] = 1;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
                if (!wraps(k) && m_cnt[k] == top_cs(k)) begin
                    m_roll[k] = 1;
                    m_go[k]   = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, advance the model, then compare every instance after the edge.
    task automatic step(input bit rs, input bit ss, input bit cl, input bit lp, input bit tk);
        rst = rs; start_stop = ss; clear = cl; lap = lp; tick = tk;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            model_step(k, rs, ss, cl, lp, tk);
            check($sformatf("disp[%0d]", k), 32'(o_disp[k]), 32'(to_bcd(m_dval[k])));
            check($sformatf("running[%0d]", k), 32'(o_run[k]), 32'(m_go[k]));
            check($sformatf("lap_active[%0d]", k), 32'(o_lap[k]), 32'(m_frozen[k]));
            check($sformatf("rollover[%0d]", k), 32'(o_roll[k]), 32'(m_roll[k]));
        end
        rst = 0; start_stop = 0; clear = 0; lap = 0; tick = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("lit_reset_disp", 32'(o_disp[0]), 32'h0);
        check("lit_reset_run", 32'(o_run[0]), 32'h0);

        // 150 ticks -> 00:01.50
        step(0, 1, 0, 0, 0);
        ticks(150);
        idle();
        check("lit_150_disp", 32'(o_disp[0]), 32'h000150);
        check("lit_150_run", 32'(o_run[0]), 32'h1);

        // Lap freeze at 00:00.42 while the live count runs on
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        ticks(42);
        step(0, 0, 0, 1, 0);
        ticks(100);
        idle();
        check("lit_lap_frozen", 32'(o_disp[0]), 32'h000042);
        check("lit_lap_active", 32'(o_lap[0]), 32'h1);
        step(0, 0, 0, 1, 0);
        idle();
        check("lit_lap_release", 32'(o_disp[0]), 32'h000142);
        check("lit_lap_off", 32'(o_lap[0]), 32'h0);

        // Stop coinciding with a tick is still counted
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        ticks(7);
        step(0, 1, 0, 0, 1);
        ticks(20);
        idle();
        check("lit_stop_tick_disp", 32'(o_disp[0]), 32'h000008);
        check("lit_stop_tick_run", 32'(o_run[0]), 32'h0);

        // clear beats start_stop
        step(0, 1, 0, 0, 0);
        ticks(5);
        step(0, 1, 1, 0, 1);
        check("lit_clr_ss_run", 32'(o_run[0]), 32'h0);
        idle();
        check("lit_clr_ss_disp", 32'(o_disp[0]), 32'h0);

        // Reset mid-count
        step(0, 1, 0, 0, 0);
        ticks(30);
        step(1, 0, 0, 0, 1);
        check("lit_rst_disp", 32'(o_disp[0]), 32'h0);
        check("lit_rst_run", 32'(o_run[0]), 32'h0);

        // Randomized control pulses
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 1) == 1);
        end

        // Terminal count on the short builds
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        ticks(59998);
        idle();
        check("lit_pre_top", 32'(o_disp[1]), 32'h095998);
        step(0, 0, 0, 0, 1);
        check("lit_sat_roll", 32'(o_roll[2]), 32'h1);
        check("lit_sat_run", 32'(o_run[2]), 32'h0);
        check("lit_wrap_noroll", 32'(o_roll[1]), 32'h0);
        step(0, 0, 0, 0, 1);
        check("lit_wrap_roll", 32'(o_roll[1]), 32'h1);
        check("lit_wrap_run", 32'(o_run[1]), 32'h1);
        check("lit_sat_roll_once", 32'(o_roll[2]), 32'h0);
        idle();
        check("lit_wrap_zero", 32'(o_disp[1]), 32'h0);
        check("lit_sat_hold", 32'(o_disp[2]), 32'h095999);
        check("lit_wrap_roll_once", 32'(o_roll[1]), 32'h0);
        step(0, 1, 0, 0, 1);
        idle();
        check("lit_sat_ss_ignored", 32'(o_run[2]), 32'h0);
        check("lit_sat_still", 32'(o_disp[2]), 32'h095999);
        step(0, 0, 1, 0, 0);
        idle();
        check("lit_sat_clear", 32'(o_disp[2]), 32'h0);

        // Random pulses around the saturated top value
        step(0, 1, 0, 0, 0);
        ticks(59990);
        for (int i = 0; i < 300; i++) begin
            step(0, $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Stopwatch core driven by the 100 Hz one-cycle tick from the slow-clock divider. The tick is used as a clock enable, never as a clock.
- Counts MM:SS.cc in BCD, with start/stop, clear and lap-freeze control.
- Outputs feed the seven-segment display multiplexer downstream.

Parameters:
- WRAP, 1: 1 = wrap 59:59.99 -> 00:00.00 with a rollover pulse; 0 = saturate at 59:59.99 and stop.
- MIN_TENS_MAX, 5: maximum value of the minutes-tens digit (59 minutes).

Ports:
- clk_in  in  1  system clock (same clock as the divider).
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle 100 Hz enable from the divider.
- start_stop  in  1  one-cycle, already-debounced pulse; toggles run/stop.
- clear  in  1  one-cycle pulse; zeroes the count.
- lap  in  1  one-cycle pulse; freezes/unfreezes the displayed value.
- disp_digits  out  24  displayed BCD digits {m10, m1, s10, s1, c10, c1}, 4 bits each.
- running  out  1  high while the count advances.
- lap_active  out  1  high while the display is frozen.
- rollover  out  1  one-cycle pulse on wrap (WRAP=1) or on reaching the saturation point (WRAP=0).

Behaviour:
- Reset:
  - All count digits = 0, display latch = 0, state = IDLE.
  - running = 0, lap_active = 0, rollover = 0.
  - rst overrides every other input.
- State machine (registered):
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE; lap -> RUN_LAP.
  - RUN_LAP: start_stop -> PAUSE_LAP; lap -> RUN.
  - PAUSE: start_stop -> RUN; lap ignored.
  - PAUSE_LAP: lap -> PAUSE; start_stop -> RUN_LAP.
  - clear, in any state -> IDLE. Clear zeroes the count and display latch and drops lap_active.
- Counting:
  - The count advances by one centisecond on a cycle where tick = 1 and the registered state is RUN or RUN_LAP.
  - A tick in the same cycle as the start_stop that leaves IDLE/PAUSE is not counted.
  - A tick in the same cycle as the start_stop that enters PAUSE is counted, because the state is still RUN.
- Digit chain:
  - c1 0..9, then c10 0..9, then s1 0..9, then s10 0..5, then m1 0..9, then m10 0..MIN_TENS_MAX.
  - Each digit carries into the next only when it wraps, within the same cycle.
  - All digits update together; no intermediate states are visible.
- Terminal count:
  - WRAP=1: the tick at 59:59.99 gives 00:00.00 and rollover = 1 for exactly that cycle. The state stays RUN/RUN_LAP.
  - WRAP=0: the tick that produces 59:59.99 pulses rollover and forces state to PAUSE (or PAUSE_LAP). The count holds at 59:59.99 until clear; start_stop from this terminal pause is ignored.
- Display:
  - disp_digits = live count, except in RUN_LAP/PAUSE_LAP, where it shows the latch.
  - The latch captures the live count in the cycle lap enters a LAP state, before any same-cycle tick increment.
  - Output latency: 1 clk_in cycle after the count register.
- Outputs:
  - running = state is RUN or RUN_LAP.
  - lap_active = state is RUN_LAP or PAUSE_LAP.
- Simultaneous inputs: priority is clear > start_stop > lap. A lower-priority pulse in the same cycle is dropped.
- Reset mid-run: the next cycle is exactly the reset state.
- Invalid BCD is unreachable; any digit >9 (or above its own limit) is forced to 0 on the next tick.

Decomposition:
- Package stopwatch_pkg:
  - State enum {IDLE, RUN, PAUSE, RUN_LAP, PAUSE_LAP}.
  - Constants: BCD_W = 4, NUM_DIGITS = 6, the per-digit maxima {MIN_TENS_MAX, 9, 5, 9, 9, 9}.
- Sub-module bcd_digit_counter:
  - Parameter MAX.
  - Ports: clk_in, rst, clr, inc, digit, carry_out.
  - Six instances, chained carry_out -> inc.

Test Plan:
- Reset, start_stop, then 150 ticks -> disp_digits = 00:01.50, running = 1, rollover never asserted.
- Preload by running to 59:59.98 (WRAP=1), then 2 ticks -> 59:59.99, then 00:00.00 with rollover high for exactly 1 cycle; running stays 1.
- Same sequence with WRAP=0 -> holds 59:59.99, rollover pulses once, running = 0; a further start_stop is ignored; clear -> 00:00.00, IDLE.
- Run to 00:00.42, lap, 100 more ticks -> display stays 00:00.42, live count 00:01.42; lap again -> display 00:01.42, lap_active = 0.
- start_stop at 00:00.07 in the same cycle as a tick -> count becomes 00:00.08 and running = 0; 20 more ticks -> still 00:00.08.
- clear and start_stop in the same cycle while RUN -> IDLE, all digits 0; rst asserted for one cycle mid-count -> all outputs 0 in the next cycle.
